// File: rtl/dbram_port_ctrl_pkg.sv
// Shared encodings for the data-BRAM port controller: access sizes, tag width,
// FSM states and the lane helpers used by both the store and load paths.
package dbram_port_ctrl_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'hF;
    endcase
  endfunction

  // Bring the addressed lane(s) down to bit 0, then truncate and extend.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] size,
                                                     input logic [1:0] off,
                                                     input logic sgn);
    logic [DATA_W-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_H:    load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

endpackage

// File: rtl/dbram_rsp_fifo.sv
// Response FIFO: DEPTH entries of WIDTH bits, first-word-fall-through output,
// simultaneous push and pop both take effect.
module dbram_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 37,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign do_pop    = pop && out_valid;
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  // Empty FIFO presents zeros so the response bus is clean out of reset.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dbram_port_ctrl.sv
// Single-port data-BRAM controller: zero-fills the RAM after reset, then serves
// byte/half/word loads and stores with in-order tagged responses.
// Define DBRAM_MISALIGN_TRAP_EN to reject misaligned halves/words with an error.
module dbram_port_ctrl
  import dbram_port_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [12:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              ram_rd_en,
  output logic [10:0]       ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  output logic [3:0]        ram_wr_en,
  output logic [10:0]       ram_wr_addr,
  output logic [31:0]       ram_wr_data,
  output logic              fsm_state
);

  localparam int FIFO_W = DATA_W + TAG_W + 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  // Handshakes: a transfer happens on any cycle where valid && ready; valid
  // holders keep their payload stable until that cycle, and ready never
  // depends combinationally on the matching valid.

  state_t             state;
  logic [10:0]        clr_cnt;

  // One-deep stage between acceptance and the FIFO push; it covers the RAM
  // read latency and keeps stores in the same slot order as loads.
  logic               st_valid;
  logic               st_load;
  logic               st_err;
  logic               st_signed;
  logic [1:0]         st_size;
  logic [1:0]         st_off;
  logic [TAG_W-1:0]   st_tag;

  logic [CNT_W-1:0]   occ;
  logic               accept;
  logic               misalign;
  logic               req_err;
  logic [1:0]         off;
  logic [DATA_W-1:0]  rsp_word;
  logic [FIFO_W-1:0]  push_data;
  logic [FIFO_W-1:0]  pop_data;

  assign fsm_state = (state == ST_RUN);
  assign req_ready = (state == ST_RUN) && ((int'(occ) + int'(st_valid)) < RSP_DEPTH);
  assign accept    = req_valid && req_ready;

  always_comb begin
    misalign = 1'b0;
`ifdef DBRAM_MISALIGN_TRAP_EN
    misalign = ((req_size == SZ_H) && req_addr[0]) ||
               ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`endif
    req_err = (req_size == SZ_RSV) || misalign;
    // Without the trap, misaligned accesses silently drop the low offset bits.
    case (req_size)
      SZ_B:    off = req_addr[1:0];
      SZ_H:    off = {req_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = req_addr[12:2];
    ram_wr_en   = 4'h0;
    ram_wr_addr = req_addr[12:2];
    ram_wr_data = 32'h0;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        ram_wr_en   = 4'hF;
        ram_wr_addr = clr_cnt;
      end else if (accept && !req_err) begin
        if (req_we) begin
          ram_wr_en = lane_mask(req_size, off);
          case (req_size)
            SZ_B:    ram_wr_data = {4{req_wdata[7:0]}};
            SZ_H:    ram_wr_data = {2{req_wdata[15:0]}};
            default: ram_wr_data = req_wdata;
          endcase
        end else begin
          ram_rd_en = 1'b1;
        end
      end
    end
  end

  assign rsp_word  = (st_load && !st_err) ? load_extract(ram_rd_data, st_size, st_off, st_signed)
                                          : '0;
  assign push_data = {rsp_word, st_tag, st_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      st_valid  <= 1'b0;
      st_load   <= 1'b0;
      st_err    <= 1'b0;
      st_signed <= 1'b0;
      st_size   <= SZ_B;
      st_off    <= 2'b00;
      st_tag    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 11'd1;
          if (clr_cnt == 11'h7FF) state <= ST_RUN;
        end
        ST_RUN: state <= ST_RUN;
        default: state <= ST_CLEAR;
      endcase
      st_valid <= accept;
      if (accept) begin
        st_load   <= !req_we;
        st_err    <= req_err;
        st_signed <= req_signed;
        st_size   <= req_size;
        st_off    <= off;
        st_tag    <= req_tag;
      end
    end
  end

  dbram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (FIFO_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (st_valid),
    .push_data (push_data),
    .pop       (rsp_ready),
    .out_valid (rsp_valid),
    .out_data  (pop_data),
    .count     (occ)
  );

  assign {rsp_data, rsp_tag, rsp_err} = pop_data;

endmodule

// File: tb/tb_dbram_port_ctrl.sv
// Bench for dbram_port_ctrl: directed vector table, backpressure/throughput/reset
// sequences, and randomized traffic scored against a byte-addressed memory model.
module tb_dbram_port_ctrl;

  localparam int RSP_DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [12:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        ram_rd_en;
  logic [10:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [3:0]  ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        fsm_state;

  int          checks = 0;
  int          errors = 0;
  int          n_pop = 0;
  logic        mon_en = 1'b0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_e;
  logic [7:0]  mem_b [8192];
  logic [31:0] ram [2048];

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_wen;
    logic        exp_rd;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  dbram_port_ctrl #(.RSP_DEPTH(RSP_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_wdata   (req_wdata),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .fsm_state   (fsm_state)
  );

  // Synchronous RAM with byte-lane writes and one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_wr_en[i]) ram[ram_wr_addr][8*i +: 8] <= ram_wr_data[8*i +: 8];
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  // ---------------- checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8192; i++) mem_b[i] = 8'h00;
  endtask

  // Reference: little-endian byte memory, naturally aligned accesses.
  task automatic model_accept(input logic we, input logic [12:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] wdata, input logic [3:0] tag);
    int          a;
    int          nb;
    logic [31:0] v;
    logic        err;
    err = (size == 2'd3);
`ifdef DBRAM_MISALIGN_TRAP_EN
    if (size == 2'd1 && addr[0]) err = 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    if (err) begin
      exp_q.push_back({32'h0, tag, 1'b1});
    end else begin
      nb = 1 << size;
      a  = int'(addr) & ~(nb - 1);
      v  = 32'h0;
      if (we) begin
        for (int i = 0; i < nb; i++) mem_b[a + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
        if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      end
      exp_q.push_back({we ? 32'h0 : v, tag, 1'b0});
    end
  endtask

  // ---------------- monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_wr_exclusive", {31'h0, ram_rd_en && (ram_wr_en != 4'h0)}, 32'h0);
      if (rsp_valid && rsp_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got tag %h data %h, expected none", rsp_tag, rsp_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_data", rsp_data, exp_e[36:5]);
          check("sb_tag_err", {27'h0, rsp_tag, rsp_err}, {27'h0, exp_e[4:0]});
        end
      end
      if (req_valid && req_ready)
        model_accept(req_we, req_addr, req_size, req_signed, req_wdata, req_tag);
    end
  end

  // ---------------- driver tasks
  task automatic send(input logic we, input logic [12:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] wdata, input logic [3:0] tag,
                      output logic [3:0] wen_s, output logic [31:0] wd_s, output logic rd_s);
    logic ok;
    ok = 1'b0;
    wen_s = 4'h0;
    wd_s = 32'h0;
    rd_s = 1'b0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_size = size;
    req_signed = sgn;
    req_wdata = wdata;
    req_tag = tag;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        wen_s = ram_wr_en;
        wd_s = ram_wr_data;
        rd_s = ram_rd_en;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0d not accepted, expected acceptance", tag);
    end
  endtask

  task automatic clear_sweep();
    int bad;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("post_rst_rsp_data", rsp_data, 32'h0);
        check("post_rst_rsp_tag_err", {27'h0, rsp_tag, rsp_err}, 32'h0);
      end
      if (req_ready !== 1'b0 || ram_wr_en !== 4'hF || ram_wr_addr !== 11'(i) ||
          ram_wr_data !== 32'h0 || ram_rd_en !== 1'b0 || fsm_state !== 1'b0)
        bad++;
    end
    check("clear_sweep_bad_cycles", 32'(bad), 32'h0);
    @(negedge clk);
    check("ready_after_clear", {31'h0, req_ready}, 32'h1);
    check("run_state_after_clear", {31'h0, fsm_state}, 32'h1);
    check("no_write_after_clear", {28'h0, ram_wr_en}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence
  initial begin
    logic [3:0]  wen_s;
    logic [31:0] wd_s;
    logic        rd_s;
    logic        got;
    logic        hs;
    logic        snap_ok;
    logic [36:0] snap;
    int          lat;
    int          acc;
    int          unstable;
    int          pops0;
    logic [31:0] cap_data;
    logic [4:0]  cap_te;

    vecs[0]  = '{1'b1, 13'h0040, 2'd2, 1'b0, 32'h8899AABB, 4'd1,  32'h0,        1'b0, 4'hF,    1'b0, 32'h8899AABB};
    vecs[1]  = '{1'b0, 13'h0041, 2'd0, 1'b1, 32'h0,        4'd2,  32'hFFFFFFAA, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[2]  = '{1'b0, 13'h0042, 2'd1, 1'b0, 32'h0,        4'd3,  32'h00008899, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[3]  = '{1'b1, 13'h0043, 2'd0, 1'b0, 32'h0000005A, 4'd4,  32'h0,        1'b0, 4'b1000, 1'b0, 32'h5A5A5A5A};
    vecs[4]  = '{1'b0, 13'h0040, 2'd2, 1'b0, 32'h0,        4'd5,  32'h5A99AABB, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[5]  = '{1'b0, 13'h0042, 2'd1, 1'b1, 32'h0,        4'd6,  32'h00005A99, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[6]  = '{1'b0, 13'h0040, 2'd0, 1'b0, 32'h0,        4'd7,  32'h000000BB, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[7]  = '{1'b0, 13'h0040, 2'd0, 1'b1, 32'h0,        4'd8,  32'hFFFFFFBB, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[8]  = '{1'b0, 13'h0040, 2'd3, 1'b0, 32'h0,        4'd9,  32'h0,        1'b1, 4'h0,    1'b0, 32'h0};
    vecs[9]  = '{1'b0, 13'h1FFC, 2'd2, 1'b0, 32'h0,        4'd10, 32'h0,        1'b0, 4'h0,    1'b1, 32'h0};
    vecs[10] = '{1'b1, 13'h1FFE, 2'd1, 1'b0, 32'h1234C3D2, 4'd11, 32'h0,        1'b0, 4'b1100, 1'b0, 32'hC3D2C3D2};
    vecs[11] = '{1'b0, 13'h1FFE, 2'd1, 1'b1, 32'h0,        4'd12, 32'hFFFFC3D2, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[12] = '{1'b0, 13'h1FFF, 2'd0, 1'b0, 32'h0,        4'd13, 32'h000000C3, 1'b0, 4'h0,    1'b1, 32'h0};
`ifdef DBRAM_MISALIGN_TRAP_EN
    vecs[13] = '{1'b0, 13'h0041, 2'd1, 1'b0, 32'h0,        4'd14, 32'h0,        1'b1, 4'h0,    1'b0, 32'h0};
    vecs[14] = '{1'b1, 13'h0045, 2'd2, 1'b0, 32'h11223344, 4'd15, 32'h0,        1'b1, 4'h0,    1'b0, 32'h0};
    vecs[15] = '{1'b0, 13'h0044, 2'd2, 1'b0, 32'h0,        4'd0,  32'h0,        1'b0, 4'h0,    1'b1, 32'h0};
`else
    vecs[13] = '{1'b0, 13'h0041, 2'd1, 1'b0, 32'h0,        4'd14, 32'h0000AABB, 1'b0, 4'h0,    1'b1, 32'h0};
    vecs[14] = '{1'b1, 13'h0045, 2'd2, 1'b0, 32'h11223344, 4'd15, 32'h0,        1'b0, 4'hF,    1'b0, 32'h11223344};
    vecs[15] = '{1'b0, 13'h0044, 2'd2, 1'b0, 32'h0,        4'd0,  32'h11223344, 1'b0, 4'h0,    1'b1, 32'h0};
`endif
    vecs[16] = '{1'b1, 13'h0040, 2'd3, 1'b0, 32'hFFFFFFFF, 4'd1,  32'h0,        1'b1, 4'h0,    1'b0, 32'h0};
    vecs[17] = '{1'b0, 13'h0040, 2'd2, 1'b0, 32'h0,        4'd2,  32'h5A99AABB, 1'b0, 4'h0,    1'b1, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_signed = 1'b0;
    req_wdata = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_ram_rd_en", {31'h0, ram_rd_en}, 32'h0);
    check("rst_ram_wr_en", {28'h0, ram_wr_en}, 32'h0);
    check("rst_fsm_state", {31'h0, fsm_state}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_sweep();
    mon_en = 1'b1;

    // Directed vector table, one request at a time
    for (int k = 0; k < NVEC; k++) begin
      send(vecs[k].we, vecs[k].addr, vecs[k].size, vecs[k].sgn, vecs[k].wdata, vecs[k].tag,
           wen_s, wd_s, rd_s);
      check($sformatf("v%0d_wen", k), {28'h0, wen_s}, {28'h0, vecs[k].exp_wen});
      check($sformatf("v%0d_rd_en", k), {31'h0, rd_s}, {31'h0, vecs[k].exp_rd});
      if (vecs[k].exp_wen != 4'h0) check($sformatf("v%0d_wdata", k), wd_s, vecs[k].exp_wdata);
      got = 1'b0;
      lat = 0;
      cap_data = 32'h0;
      cap_te = 5'h0;
      for (int c = 1; c <= 20 && !got; c++) begin
        @(negedge clk);
        if (rsp_valid) begin
          got = 1'b1;
          lat = c;
          cap_data = rsp_data;
          cap_te = {rsp_tag, rsp_err};
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL v%0d_rsp_timeout: no response, expected one", k);
      end else begin
        check($sformatf("v%0d_data", k), cap_data, vecs[k].exp_data);
        check($sformatf("v%0d_tag_err", k), {27'h0, cap_te}, {27'h0, vecs[k].tag, vecs[k].exp_err});
        if (!vecs[k].we) check($sformatf("v%0d_latency", k), 32'(lat), 32'd2);
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: rsp_ready low, req_valid high for 10 cycles
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'd2;
    req_signed = 1'b0;
    req_tag = 4'd0;
    req_addr = 13'h0040;
    acc = 0;
    unstable = 0;
    snap_ok = 1'b0;
    snap = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hs = req_ready;
      if (hs) acc++;
      if (rsp_valid) begin
        if (!snap_ok) begin
          snap = {rsp_data, rsp_tag, rsp_err};
          snap_ok = 1'b1;
        end else if ({rsp_data, rsp_tag, rsp_err} !== snap) begin
          unstable++;
        end
      end
      @(posedge clk);
      #1;
      if (hs) begin
        req_tag = req_tag + 4'd1;
        req_addr = 13'h0040 + 13'(req_tag) * 13'd4;
      end
    end
    req_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'(RSP_DEPTH));
    check("bp_rsp_seen", {31'h0, snap_ok}, 32'h1);
    check("bp_unstable_cycles", 32'(unstable), 32'h0);
    pops0 = n_pop;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("bp_drained", 32'(n_pop - pops0), 32'(RSP_DEPTH));
    check("bp_queue_empty", 32'(exp_q.size()), 32'h0);

    // Throughput: both sides ready, one request per cycle
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b1;
    req_addr = 13'h0041;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      hs = req_ready;
      if (hs) acc++;
      @(posedge clk);
      #1;
      req_tag = req_tag + 4'd1;
    end
    req_valid = 1'b0;
    check("throughput_accepts", 32'(acc), 32'd8);
    repeat (5) @(posedge clk);
    #1;
    check("tp_queue_empty", 32'(exp_q.size()), 32'h0);

    // Randomized traffic with random response backpressure
    hs = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!req_valid || hs) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we = 1'($urandom_range(0, 1));
        req_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        req_addr = (($urandom_range(0, 1) == 1) ? 13'h1FC0 : 13'h0000) + 13'($urandom_range(0, 63));
        req_signed = 1'($urandom_range(0, 1));
        req_wdata = $urandom;
        req_tag = 4'($urandom_range(0, 15));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = req_valid && req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (exp_q.size() != 0 || rsp_valid); c++) begin
      @(posedge clk);
      #1;
    end
    check("rand_queue_drained", 32'(exp_q.size()), 32'h0);

    // Reset with two responses queued
    rsp_ready = 1'b0;
    send(1'b0, 13'h0040, 2'd2, 1'b0, 32'h0, 4'd3, wen_s, wd_s, rd_s);
    send(1'b0, 13'h0044, 2'd2, 1'b0, 32'h0, 4'd4, wen_s, wd_s, rd_s);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queued_before_rst", {31'h0, rsp_valid}, 32'h1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    rsp_ready = 1'b1;
    clear_sweep();
    mon_en = 1'b1;

    // Memory is zero again after the restarted clear
    pops0 = n_pop;
    send(1'b0, 13'h0040, 2'd2, 1'b0, 32'h0, 4'd9, wen_s, wd_s, rd_s);
    repeat (4) @(posedge clk);
    #1;
    check("post_clear_load_rsp", 32'(n_pop - pops0), 32'h1);
    check("post_clear_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
